// File: rtl/sketch_mask_pipe.sv
// Three-stage sketch-mask pipeline: channel sums, divide-by-3 to gray/gradient, then mode mux
// and a per-frame edge-pixel counter. Threshold and mode are latched per frame on the sof pixel.
module sketch_mask_pipe #(
    parameter int DATA_W         = 8,
    parameter int THRESH_DEFAULT = 50,
    parameter int GAIN_SHIFT     = 1,
    parameter int CNT_W          = 20
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_sof,
    input  logic [DATA_W-1:0] iRed,
    input  logic [DATA_W-1:0] iGreen,
    input  logic [DATA_W-1:0] iBlue,
    input  logic [DATA_W-1:0] iRed_G1,
    input  logic [DATA_W-1:0] iGreen_G1,
    input  logic [DATA_W-1:0] iBlue_G1,
    input  logic [DATA_W-1:0] i_thresh,
    input  logic [1:0]        i_mode,
    output logic              o_valid,
    output logic              o_sof,
    output logic [DATA_W-1:0] oRed,
    output logic [DATA_W-1:0] oGreen,
    output logic [DATA_W-1:0] oBlue,
    output logic [CNT_W-1:0]  o_edge_count,
    output logic              o_count_valid
);
    localparam int SW = DATA_W + 2;
    localparam int KW = DATA_W + 3;
    localparam logic [SW-1:0]     THREE  = SW'(3);
    localparam logic [DATA_W-1:0] MAX    = '1;
    localparam logic [DATA_W-1:0] THR_RST = DATA_W'(THRESH_DEFAULT);

    // Frame-level shadows of threshold and mode
    logic [DATA_W-1:0] thr_q, thr_d;
    logic [1:0]        mode_q, mode_d;
    logic              load;

    logic              s1_vld_q, s1_sof_q;
    logic [SW-1:0]     s1_sum_q, s1_sg_q;
    logic [DATA_W-1:0] s1_r_q, s1_g_q, s1_b_q, s1_thr_q;
    logic [1:0]        s1_mode_q;

    logic              s2_vld_q, s2_sof_q;
    logic [DATA_W-1:0] s2_gray_q, s2_grad_q, s2_r_q, s2_g_q, s2_b_q, s2_thr_q;
    logic [1:0]        s2_mode_q;

    logic              vld_q, sof_q, cv_q, cv_d;
    logic [DATA_W-1:0] r_q, g_q, b_q, r_d, g_d, b_d;
    logic [CNT_W-1:0]  acc_q, acc_d, cnt_q, cnt_d;

    logic              edge_px;
    logic [KW-1:0]     shifted;
    logic [DATA_W-1:0] sk;

    assign load   = i_valid & i_sof;
    assign thr_d  = load ? i_thresh : thr_q;
    assign mode_d = load ? i_mode : mode_q;

    // Stage 1: sums, passthrough, and frame parameters bound to the pixel
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            thr_q     <= THR_RST;
            mode_q    <= 2'd1;
            s1_vld_q  <= 1'b0;
            s1_sof_q  <= 1'b0;
            s1_sum_q  <= '0;
            s1_sg_q   <= '0;
            s1_r_q    <= '0;
            s1_g_q    <= '0;
            s1_b_q    <= '0;
            s1_thr_q  <= '0;
            s1_mode_q <= '0;
        end else begin
            thr_q     <= thr_d;
            mode_q    <= mode_d;
            s1_vld_q  <= i_valid;
            s1_sof_q  <= load;
            s1_sum_q  <= SW'(iRed) + SW'(iGreen) + SW'(iBlue);
            s1_sg_q   <= SW'(iRed_G1) + SW'(iGreen_G1) + SW'(iBlue_G1);
            s1_r_q    <= iRed;
            s1_g_q    <= iGreen;
            s1_b_q    <= iBlue;
            s1_thr_q  <= thr_d;
            s1_mode_q <= mode_d;
        end
    end

    // Stage 2: exact divide-by-3; quotient of a 3*MAX sum always fits DATA_W
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s2_vld_q  <= 1'b0;
            s2_sof_q  <= 1'b0;
            s2_gray_q <= '0;
            s2_grad_q <= '0;
            s2_r_q    <= '0;
            s2_g_q    <= '0;
            s2_b_q    <= '0;
            s2_thr_q  <= '0;
            s2_mode_q <= '0;
        end else begin
            s2_vld_q  <= s1_vld_q;
            s2_sof_q  <= s1_sof_q;
            s2_gray_q <= DATA_W'(s1_sum_q / THREE);
            s2_grad_q <= DATA_W'(s1_sg_q / THREE);
            s2_r_q    <= s1_r_q;
            s2_g_q    <= s1_g_q;
            s2_b_q    <= s1_b_q;
            s2_thr_q  <= s1_thr_q;
            s2_mode_q <= s1_mode_q;
        end
    end

    assign edge_px = s2_grad_q > s2_thr_q;
    assign shifted = KW'(s2_gray_q) << GAIN_SHIFT;
    assign sk      = (shifted > KW'(MAX)) ? MAX : shifted[DATA_W-1:0];

    always_comb begin
        r_d = s2_r_q;
        g_d = s2_g_q;
        b_d = s2_b_q;
        unique case (s2_mode_q)
            2'd0: ;
            2'd1: begin
                r_d = edge_px ? '0 : sk;
                g_d = r_d;
                b_d = r_d;
            end
            2'd2: begin
                r_d = edge_px ? MAX : MAX - sk;
                g_d = r_d;
                b_d = r_d;
            end
            default: begin
                r_d = edge_px ? '0 : MAX;
                g_d = r_d;
                b_d = r_d;
            end
        endcase
    end

    // Sof pixel publishes the finished frame and seeds the new one with its own edge bit
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        cv_d  = 1'b0;
        if (s2_vld_q) begin
            if (s2_sof_q) begin
                cnt_d = acc_q;
                cv_d  = 1'b1;
                acc_d = CNT_W'(edge_px);
            end else if (edge_px && acc_q != '1) begin
                acc_d = acc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vld_q <= 1'b0;
            sof_q <= 1'b0;
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            cv_q  <= 1'b0;
        end else begin
            vld_q <= s2_vld_q;
            sof_q <= s2_sof_q;
            r_q   <= r_d;
            g_q   <= g_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            cv_q  <= cv_d;
        end
    end

    assign o_valid       = vld_q;
    assign o_sof         = sof_q;
    assign oRed          = r_q;
    assign oGreen        = g_q;
    assign oBlue         = b_q;
    assign o_edge_count  = cnt_q;
    assign o_count_valid = cv_q;
endmodule

// File: tb/tb_sketch_mask_pipe.sv
// Randomised and directed stimulus for sketch_mask_pipe against a per-pixel arithmetic model
// whose expected results are queued three cycles ahead of the DUT outputs.
module tb_sketch_mask_pipe;
    localparam int DATA_W = 8;
    localparam int TDEF   = 50;
    localparam int GS     = 1;
    localparam int CNT_W  = 4;
    localparam int MAX    = (1 << DATA_W) - 1;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_valid = 1'b0, i_sof = 1'b0;
    logic [DATA_W-1:0] iRed = '0, iGreen = '0, iBlue = '0;
    logic [DATA_W-1:0] iRed_G1 = '0, iGreen_G1 = '0, iBlue_G1 = '0;
    logic [DATA_W-1:0] i_thresh = '0;
    logic [1:0]        i_mode = '0;
    logic              o_valid, o_sof, o_count_valid;
    logic [DATA_W-1:0] oRed, oGreen, oBlue;
    logic [CNT_W-1:0]  o_edge_count;

    sketch_mask_pipe #(.DATA_W(DATA_W), .THRESH_DEFAULT(TDEF), .GAIN_SHIFT(GS), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_sof(i_sof),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .iRed_G1(iRed_G1), .iGreen_G1(iGreen_G1), .iBlue_G1(iBlue_G1),
        .i_thresh(i_thresh), .i_mode(i_mode),
        .o_valid(o_valid), .o_sof(o_sof), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
        .o_edge_count(o_edge_count), .o_count_valid(o_count_valid)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit v, s, cv, z;
        int r, g, b, cnt;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0, n_fail = 0;
    int   cur_th = TDEF, cur_md = 1;
    int   m_thr, m_mode, m_acc, m_pub;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit v, input bit s,
                        input int r, input int g, input int b,
                        input int gr, input int gg, input int gb);
        exp_t e;
        int gray, grad, sk, px;
        bit edge_b;
        @(negedge i_clk);
        i_rst_n = !rst;
        i_valid = v;  i_sof = s;
        iRed = DATA_W'(r);  iGreen = DATA_W'(g);  iBlue = DATA_W'(b);
        iRed_G1 = DATA_W'(gr);  iGreen_G1 = DATA_W'(gg);  iBlue_G1 = DATA_W'(gb);
        i_thresh = DATA_W'(cur_th);  i_mode = 2'(cur_md);
        e = '{v: 0, s: 0, cv: 0, z: 0, r: 0, g: 0, b: 0, cnt: 0};
        if (rst) begin
            q.delete();
            m_thr = TDEF;  m_mode = 1;  m_acc = 0;  m_pub = 0;
            e.z = 1;
            q.push_back(e);
            e.z = 0;
            q.push_back(e);
            q.push_back(e);
        end else begin
            if (v) begin
                if (s) begin
                    m_thr = cur_th;
                    m_mode = cur_md;
                end
                gray   = (r + g + b) / 3;
                grad   = (gr + gg + gb) / 3;
                edge_b = grad > m_thr;
                sk     = (gray * (1 << GS) > MAX) ? MAX : gray * (1 << GS);
                case (m_mode)
                    0: begin e.r = r; e.g = g; e.b = b; end
                    1: begin px = edge_b ? 0 : sk;         e.r = px; e.g = px; e.b = px; end
                    2: begin px = edge_b ? MAX : MAX - sk; e.r = px; e.g = px; e.b = px; end
                    default: begin px = edge_b ? 0 : MAX;  e.r = px; e.g = px; e.b = px; end
                endcase
                if (s) begin
                    m_pub = m_acc;
                    m_acc = int'(edge_b);
                    e.cv  = 1;
                end else begin
                    m_acc = (m_acc + int'(edge_b) > CMAX) ? CMAX : m_acc + int'(edge_b);
                end
                e.v = 1;
                e.s = s;
            end
            e.cnt = m_pub;
            q.push_back(e);
        end
        @(posedge i_clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("o_valid", 32'(o_valid), 32'(e.v));
            check("o_sof", 32'(o_sof), 32'(e.s));
            check("o_count_valid", 32'(o_count_valid), 32'(e.cv));
            check("o_edge_count", 32'(o_edge_count), 32'(e.cnt));
            if (e.v || e.z) begin
                check("oRed", 32'(oRed), 32'(e.r));
                check("oGreen", 32'(oGreen), 32'(e.g));
                check("oBlue", 32'(oBlue), 32'(e.b));
            end
        end
    endtask

    task automatic px(input bit s, input int r, input int g, input int b, input int gv);
        step(0, 1, s, r, g, b, gv, gv, gv);
    endtask

    task automatic bubble();
        step(0, 0, 0, 0, 0, 0, 255, 255, 255);
    endtask

    initial begin
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // sketch mode, all-edge frame of four
        cur_th = 50; cur_md = 1;
        px(1, 30, 30, 30, 60);
        repeat (3) px(0, 30, 30, 30, 60);
        px(1, 200, 100, 0, 50);
        px(0, 255, 255, 255, 0);

        cur_md = 2;
        px(1, 200, 100, 0, 50);
        px(0, 255, 255, 255, 0);
        px(0, 10, 10, 10, 200);
        cur_md = 3;
        px(1, 20, 20, 20, 10);
        cur_md = 0;
        px(1, 12, 34, 56, 200);

        // mid-frame parameter change is deferred to the next sof
        cur_th = 50; cur_md = 1;
        px(1, 40, 40, 40, 60);
        cur_th = 70; cur_md = 3;
        px(0, 40, 40, 40, 60);
        px(0, 40, 40, 40, 60);
        px(1, 40, 40, 40, 60);

        // valid pattern 1,0,1,1,0 with high gradient under bubbles
        px(0, 1, 2, 3, 100);
        bubble();
        px(0, 4, 5, 6, 100);
        px(0, 7, 8, 9, 10);
        bubble();

        // back-to-back sof pixels
        px(1, 50, 50, 50, 100);
        px(1, 60, 60, 60, 10);
        px(1, 70, 70, 70, 100);

        // counter saturation
        cur_th = 50; cur_md = 1;
        px(1, 5, 5, 5, 200);
        repeat (19) px(0, 5, 5, 5, 200);
        px(1, 5, 5, 5, 0);

        // reset mid-frame
        repeat (3) px(0, 5, 5, 5, 200);
        step(1, 1, 0, 5, 5, 5, 200, 200, 200);
        px(0, 5, 5, 5, 200);
        px(0, 5, 5, 5, 200);
        px(1, 5, 5, 5, 0);
        bubble();

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                cur_th = $urandom_range(0, MAX);
                cur_md = $urandom_range(0, 3);
            end
            if ($urandom_range(0, 199) == 0)
                step(1, 1, 1, 0, 0, 0, 0, 0, 0);
            else
                step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, MAX), $urandom_range(0, MAX), $urandom_range(0, MAX),
                     $urandom_range(0, MAX), $urandom_range(0, MAX), $urandom_range(0, MAX));
        end
        repeat (4) bubble();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
